vec_issue_ctrl: RTL and testbench
=================================

Name: vec_issue_ctrl

Overview:
- Registered, parametrised successor of the combinational decode/BEQ controller.
- Decodes one instruction per handshake into pipeline control signals.
- Sequences vector ops (RVtype, LW_V, SW_V) as multi-beat issues over LANES lanes.
- Runs a branch-resolve/flush FSM with a configurable flush depth. Sits between the instruction fetch register and the EX stage, with backpressure both ways.

Parameters:
- INSTR_W, 32, instruction width; opcode = instn[INSTR_W-1 -: 6].
- VLEN, 8, elements per vector register (≥1).
- LANES, 4, elements processed per beat (1..VLEN).
- BR_FLUSH, 2, flush cycles after a taken branch (≥1).
- Derived: BEATS = ceil(VLEN/LANES); EW = max(1, $clog2(VLEN)).

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- instn  in  INSTR_W  instruction
- instn_valid  in  1  instruction present
- instn_ready  out  1  instruction accepted when valid&ready
- ex_ready  out→in  1  EX stage can take a control word (input)
- br_valid  in  1  branch outcome valid
- pcsrc  in  1  branch taken (sampled with br_valid)
- ctl_valid  out  1  control word valid
- opcode  out  6  registered opcode
- reg_dst, alu_src, branch, mem_write, reg_write, mem_to_reg, vreg_write  out  1 each  control lines
- alu_op  out  2  ALU op class
- elem_base  out  EW  first element index of this beat
- lane_mask  out  LANES  active lanes this beat
- vec_last  out  1  final beat of a vector op
- flush  out  1  squash younger instructions
- state  out  2  FSM state

Behaviour:
- Reset (async, rst_n=0): all outputs 0; state=NORMAL(00).
- Output register: loads on a new word when `!ctl_valid || ex_ready`. Otherwise it holds every output stable. ctl_valid drops to 0 after consumption if no new word is ready.
- Decode table, per opcode (others 0; mem_write=1 only for SW/SW_R/SW_V):
  - Rtype: reg_dst=1, alu_op=10, reg_write=1.
  - RVtype: reg_dst=1, alu_op=10, vreg_write=1.
  - LW: alu_op=10, alu_src=1, reg_write=1, mem_to_reg=1.
  - SW: alu_op=00, alu_src=1, mem_write=1.
  - LW_R, LW_V: reg_dst=1, alu_op=10, reg_write=1, mem_to_reg=1.
  - SW_R, SW_V: reg_dst=1, alu_op=10, mem_write=1.
  - BEQ: alu_op=01, branch=1.
  - ADDI, SET: alu_op=00, alu_src=1, reg_write=1.
  - Unknown: all 0 (NOP word, ctl_valid still 1).
- Scalar words: elem_base=0, lane_mask=all 1s, vec_last=1.
- instn_ready = (state==NORMAL) && (!ctl_valid || ex_ready). Combinational, no dependence on instn_valid.
- States: NORMAL=00, VEC=01, BR_WAIT=10, BR_FLUSH=11.
- NORMAL:
  - Accepts an instruction; emits its word.
  - Vector opcode with BEATS>1 → VEC, beat counter=1.
  - BEQ → BR_WAIT.
  - Otherwise stays in NORMAL.
- VEC:
  - Each loaded beat b emits the same controls, elem_base=b*LANES, lane_mask=low min(LANES, VLEN-b*LANES) bits set.
  - vec_last=1 on beat BEATS-1, then → NORMAL.
  - Beats advance only on output-register load (backpressure holds the counter). No new instruction is accepted.
- BR_WAIT:
  - Waits for br_valid; ignores pcsrc otherwise.
  - br_valid & !pcsrc → NORMAL next cycle.
  - br_valid & pcsrc → BR_FLUSH, flush counter=BR_FLUSH.
- BR_FLUSH:
  - flush=1 for exactly BR_FLUSH cycles; ctl_valid forced 0 on the first of them.
  - Then → NORMAL; flush deasserts in the same cycle.
- Edge cases:
  - br_valid in NORMAL/VEC is ignored.
  - VLEN==LANES: vector ops are single-beat and never enter VEC.
  - Reset mid-VEC or mid-flush: immediate return to NORMAL, all outputs 0.

Optional Feature:
- Macro: VEC_ISSUE_ILLEGAL_TRAP_EN.
- Defined:
  - Adds output `illegal_op` (1 bit).
  - An unknown opcode sets illegal_op=1 (sticky) and emits no word (ctl_valid=0).
  - The FSM stays in NORMAL with instn_ready=0 until reset.
- Undefined: unknown opcodes issue an all-zero NOP word as above; the port is absent.

Test Plan:
- Reset mid-operation: assert rst_n=0 mid-run → all outputs 0 asynchronously, state=00. Release, send ADDI → alu_src=1, reg_write=1, alu_op=00 one cycle after accept.
- RVtype, VLEN=8/LANES=4, ex_ready=1 → two beats: elem_base 0 then 4, lane_mask 1111/1111, vec_last 0 then 1. instn_ready low during beat 1.
- Same op with VLEN=6/LANES=4 → second beat elem_base=4, lane_mask=0011. Hold ex_ready=0 for 3 cycles on beat 0 → outputs stable, counter does not advance.
- BEQ, then br_valid=1, pcsrc=0 after 2 cycles → branch=1 word; state 10 for 2 cycles, then 00; flush never asserted.
- BEQ, then br_valid=1, pcsrc=1, BR_FLUSH=2 → state 11, flush high exactly 2 cycles, then instn_ready=1.
- Unknown opcode 111111 → without the macro: ctl_valid=1, all controls 0. With VEC_ISSUE_ILLEGAL_TRAP_EN: illegal_op=1, instn_ready stays 0 until reset.

Source files
------------

// File: rtl/vec_issue_ctrl.sv
// vec_issue_ctrl: registered instruction decoder with multi-beat vector issue and a branch-resolve/flush FSM.
// Optional feature macro: VEC_ISSUE_ILLEGAL_TRAP_EN (sticky illegal_op trap on unknown opcodes).
module vec_issue_ctrl #(
  parameter int INSTR_W  = 32,
  parameter int VLEN     = 8,
  parameter int LANES    = 4,
  parameter int BR_FLUSH = 2,
  localparam int EW      = (VLEN > 1) ? $clog2(VLEN) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instn,
  input  logic               instn_valid,
  output logic               instn_ready,
  input  logic               ex_ready,
  input  logic               br_valid,
  input  logic               pcsrc,
  output logic               ctl_valid,
  output logic [5:0]         opcode,
  output logic               reg_dst,
  output logic               alu_src,
  output logic               branch,
  output logic               mem_write,
  output logic               reg_write,
  output logic               mem_to_reg,
  output logic               vreg_write,
  output logic [1:0]         alu_op,
  output logic [EW-1:0]      elem_base,
  output logic [LANES-1:0]   lane_mask,
  output logic               vec_last,
  output logic               flush,
`ifdef VEC_ISSUE_ILLEGAL_TRAP_EN
  output logic               illegal_op,
`endif
  output logic [1:0]         state
);

  localparam int BEATS      = (VLEN + LANES - 1) / LANES;
  localparam int BW         = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int FW         = $clog2(BR_FLUSH + 1);
  localparam bit MULTI_BEAT = (BEATS > 1);

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_RVTYPE = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_SET    = 6'b001111;
  localparam logic [5:0] OP_LW_R   = 6'b100000;
  localparam logic [5:0] OP_LW_V   = 6'b100001;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW_R   = 6'b101000;
  localparam logic [5:0] OP_SW_V   = 6'b101001;
  localparam logic [5:0] OP_SW     = 6'b101011;

  typedef enum logic [1:0] {
    ST_NORMAL   = 2'b00,
    ST_VEC      = 2'b01,
    ST_BR_WAIT  = 2'b10,
    ST_BR_FLUSH = 2'b11
  } state_t;

  typedef struct packed {
    logic       known;
    logic       is_vec;
    logic       reg_dst;
    logic       alu_src;
    logic       branch;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       vreg_write;
    logic [1:0] alu_op;
  } dec_t;

  state_t           state_q;
  dec_t             dec;
  logic [5:0]       op_in;
  logic [BW-1:0]    beat_cnt;
  logic [BW-1:0]    beat_sel;
  logic [LANES-1:0] beat_mask;
  logic [EW-1:0]    beat_base;
  logic             beat_last;
  logic [FW-1:0]    flush_cnt;
  logic             load_en;
  logic             ready_core;
  logic             accept;
  logic             unused_bits;

  assign op_in       = instn[INSTR_W-1 -: 6];
  assign unused_bits = ^{instn[INSTR_W-7:0], dec.known};
  assign state       = state_q;

  always_comb begin
    dec       = '0;
    dec.known = 1'b1;
    case (op_in)
      OP_RTYPE:  begin dec.reg_dst = 1'b1; dec.alu_op = 2'b10; dec.reg_write = 1'b1; end
      OP_RVTYPE: begin dec.reg_dst = 1'b1; dec.alu_op = 2'b10; dec.vreg_write = 1'b1; dec.is_vec = 1'b1; end
      OP_LW:     begin dec.alu_op = 2'b10; dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.mem_to_reg = 1'b1; end
      OP_SW:     begin dec.alu_op = 2'b00; dec.alu_src = 1'b1; dec.mem_write = 1'b1; end
      OP_LW_R:   begin dec.reg_dst = 1'b1; dec.alu_op = 2'b10; dec.reg_write = 1'b1; dec.mem_to_reg = 1'b1; end
      OP_LW_V:   begin dec.reg_dst = 1'b1; dec.alu_op = 2'b10; dec.reg_write = 1'b1; dec.mem_to_reg = 1'b1;
                       dec.is_vec = 1'b1; end
      OP_SW_R:   begin dec.reg_dst = 1'b1; dec.alu_op = 2'b10; dec.mem_write = 1'b1; end
      OP_SW_V:   begin dec.reg_dst = 1'b1; dec.alu_op = 2'b10; dec.mem_write = 1'b1; dec.is_vec = 1'b1; end
      OP_BEQ:    begin dec.alu_op = 2'b01; dec.branch = 1'b1; end
      OP_ADDI,
      OP_SET:    begin dec.alu_op = 2'b00; dec.alu_src = 1'b1; dec.reg_write = 1'b1; end
      default:   dec.known = 1'b0;
    endcase
  end

  // Beat geometry; outside VEC this always describes beat 0.
  assign beat_sel  = (state_q == ST_VEC) ? beat_cnt : '0;
  assign beat_base = EW'(int'(beat_sel) * LANES);
  assign beat_last = (int'(beat_sel) == BEATS - 1);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign beat_mask[gi] = ((int'(beat_sel) * LANES + gi) < VLEN);
  end

  assign load_en = !ctl_valid || ex_ready;

`ifdef VEC_ISSUE_ILLEGAL_TRAP_EN
  assign ready_core = (state_q == ST_NORMAL) && load_en && !illegal_op;
`else
  assign ready_core = (state_q == ST_NORMAL) && load_en;
`endif

  // Reset only masks the visible ready; no flop sees rst_n as data.
  assign instn_ready = ready_core && rst_n;
  assign accept      = instn_valid && ready_core;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_NORMAL;
      ctl_valid  <= 1'b0;
      opcode     <= '0;
      reg_dst    <= 1'b0;
      alu_src    <= 1'b0;
      branch     <= 1'b0;
      mem_write  <= 1'b0;
      reg_write  <= 1'b0;
      mem_to_reg <= 1'b0;
      vreg_write <= 1'b0;
      alu_op     <= '0;
      elem_base  <= '0;
      lane_mask  <= '0;
      vec_last   <= 1'b0;
      flush      <= 1'b0;
      beat_cnt   <= '0;
      flush_cnt  <= '0;
`ifdef VEC_ISSUE_ILLEGAL_TRAP_EN
      illegal_op <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_NORMAL: begin
          if (accept) begin
`ifdef VEC_ISSUE_ILLEGAL_TRAP_EN
            if (!dec.known) begin
              illegal_op <= 1'b1;
              ctl_valid  <= 1'b0;
            end else
`endif
            begin
              ctl_valid  <= 1'b1;
              opcode     <= op_in;
              reg_dst    <= dec.reg_dst;
              alu_src    <= dec.alu_src;
              branch     <= dec.branch;
              mem_write  <= dec.mem_write;
              reg_write  <= dec.reg_write;
              mem_to_reg <= dec.mem_to_reg;
              vreg_write <= dec.vreg_write;
              alu_op     <= dec.alu_op;
              elem_base  <= '0;
              if (dec.is_vec && MULTI_BEAT) begin
                lane_mask <= beat_mask;
                vec_last  <= 1'b0;
                beat_cnt  <= BW'(1);
                state_q   <= ST_VEC;
              end else begin
                lane_mask <= '1;
                vec_last  <= 1'b1;
                if (dec.branch) begin
                  state_q <= ST_BR_WAIT;
                end
              end
            end
          end else if (load_en) begin
            ctl_valid <= 1'b0;
          end
        end

        // Control lines stay as loaded by beat 0; only beat geometry changes.
        ST_VEC: begin
          if (load_en) begin
            ctl_valid <= 1'b1;
            elem_base <= beat_base;
            lane_mask <= beat_mask;
            vec_last  <= beat_last;
            if (beat_last) begin
              beat_cnt <= '0;
              state_q  <= ST_NORMAL;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end

        ST_BR_WAIT: begin
          if (load_en) begin
            ctl_valid <= 1'b0;
          end
          if (br_valid) begin
            if (pcsrc) begin
              ctl_valid <= 1'b0;
              flush     <= 1'b1;
              flush_cnt <= FW'(BR_FLUSH);
              state_q   <= ST_BR_FLUSH;
            end else begin
              state_q <= ST_NORMAL;
            end
          end
        end

        ST_BR_FLUSH: begin
          if (load_en) begin
            ctl_valid <= 1'b0;
          end
          if (flush_cnt == FW'(1)) begin
            flush     <= 1'b0;
            flush_cnt <= '0;
            state_q   <= ST_NORMAL;
          end else begin
            flush_cnt <= flush_cnt - 1'b1;
          end
        end

        default: state_q <= ST_NORMAL;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_issue_ctrl.sv
// Testbench for vec_issue_ctrl: scoreboard of expected control words plus directed FSM checks,
// run on two instances (VLEN=8 and VLEN=6, LANES=4) driven by the same stimulus.
module tb_vec_issue_ctrl;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_RVTYPE = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_SET    = 6'b001111;
  localparam logic [5:0] OP_LW_R   = 6'b100000;
  localparam logic [5:0] OP_LW_V   = 6'b100001;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW_R   = 6'b101000;
  localparam logic [5:0] OP_SW_V   = 6'b101001;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] OP_BAD    = 6'b111111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instn = '0;
  logic        instn_valid = 1'b0;
  logic        ex_ready = 1'b1;
  logic        br_valid = 1'b0;
  logic        pcsrc = 1'b0;

  logic       instn_ready, ctl_valid, reg_dst, alu_src, branch, mem_write, reg_write;
  logic       mem_to_reg, vreg_write, vec_last, flush;
  logic [5:0] opcode;
  logic [1:0] alu_op, state;
  logic [2:0] elem_base;
  logic [3:0] lane_mask;

  logic       instn_ready_b, ctl_valid_b, reg_dst_b, alu_src_b, branch_b, mem_write_b, reg_write_b;
  logic       mem_to_reg_b, vreg_write_b, vec_last_b, flush_b;
  logic [5:0] opcode_b;
  logic [1:0] alu_op_b, state_b;
  logic [2:0] elem_base_b;
  logic [3:0] lane_mask_b;
`ifdef VEC_ISSUE_ILLEGAL_TRAP_EN
  logic       illegal_op, illegal_op_b;
`endif

  always #5 clk = ~clk;

  vec_issue_ctrl #(.INSTR_W(32), .VLEN(8), .LANES(4), .BR_FLUSH(2)) dut (
    .clk(clk), .rst_n(rst_n), .instn(instn), .instn_valid(instn_valid), .instn_ready(instn_ready),
    .ex_ready(ex_ready), .br_valid(br_valid), .pcsrc(pcsrc), .ctl_valid(ctl_valid), .opcode(opcode),
    .reg_dst(reg_dst), .alu_src(alu_src), .branch(branch), .mem_write(mem_write), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .vreg_write(vreg_write), .alu_op(alu_op), .elem_base(elem_base),
    .lane_mask(lane_mask), .vec_last(vec_last), .flush(flush),
`ifdef VEC_ISSUE_ILLEGAL_TRAP_EN
    .illegal_op(illegal_op),
`endif
    .state(state)
  );

  vec_issue_ctrl #(.INSTR_W(32), .VLEN(6), .LANES(4), .BR_FLUSH(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .instn(instn), .instn_valid(instn_valid), .instn_ready(instn_ready_b),
    .ex_ready(ex_ready), .br_valid(br_valid), .pcsrc(pcsrc), .ctl_valid(ctl_valid_b), .opcode(opcode_b),
    .reg_dst(reg_dst_b), .alu_src(alu_src_b), .branch(branch_b), .mem_write(mem_write_b),
    .reg_write(reg_write_b), .mem_to_reg(mem_to_reg_b), .vreg_write(vreg_write_b), .alu_op(alu_op_b),
    .elem_base(elem_base_b), .lane_mask(lane_mask_b), .vec_last(vec_last_b), .flush(flush_b),
`ifdef VEC_ISSUE_ILLEGAL_TRAP_EN
    .illegal_op(illegal_op_b),
`endif
    .state(state_b)
  );

  typedef struct {
    logic [5:0] op;
    logic [8:0] ctl;
    logic [2:0] base;
    logic [3:0] mask8;
    logic [3:0] mask6;
    logic       last;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  exp_t       drop_e;
  int         n_err = 0;
  int         n_checks = 0;
  bit         rand_rdy = 1'b0;
  int         nfl;
  logic [5:0] mix [10] = '{OP_RTYPE, OP_RVTYPE, OP_LW, OP_SW, OP_LW_R, OP_LW_V,
                           OP_SW_R, OP_SW_V, OP_ADDI, OP_SET};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // {reg_dst, alu_src, branch, mem_write, reg_write, mem_to_reg, vreg_write, alu_op[1:0]}
  function automatic logic [8:0] exp_ctl(input logic [5:0] op);
    case (op)
      OP_RTYPE:         return 9'b1_0_0_0_1_0_0_10;
      OP_RVTYPE:        return 9'b1_0_0_0_0_0_1_10;
      OP_LW:            return 9'b0_1_0_0_1_1_0_10;
      OP_SW:            return 9'b0_1_0_1_0_0_0_00;
      OP_LW_R, OP_LW_V: return 9'b1_0_0_0_1_1_0_10;
      OP_SW_R, OP_SW_V: return 9'b1_0_0_1_0_0_0_10;
      OP_BEQ:           return 9'b0_0_1_0_0_0_0_01;
      OP_ADDI, OP_SET:  return 9'b0_1_0_0_1_0_0_00;
      default:          return 9'b0;
    endcase
  endfunction

  function automatic bit is_vec_op(input logic [5:0] op);
    return (op == OP_RVTYPE) || (op == OP_LW_V) || (op == OP_SW_V);
  endfunction

  function automatic bit known_op(input logic [5:0] op);
    return (op == OP_BEQ) || (exp_ctl(op) != 9'b0) || (op == OP_RTYPE);
  endfunction

  task automatic push_expected(input logic [5:0] op);
    exp_t e;
`ifdef VEC_ISSUE_ILLEGAL_TRAP_EN
    if (!known_op(op)) return;
`endif
    e.op  = op;
    e.ctl = exp_ctl(op);
    if (is_vec_op(op)) begin
      e.base = 3'd0; e.mask8 = 4'hF; e.mask6 = 4'hF; e.last = 1'b0; sb_q.push_back(e);
      e.base = 3'd4; e.mask8 = 4'hF; e.mask6 = 4'h3; e.last = 1'b1; sb_q.push_back(e);
    end else begin
      e.base = 3'd0; e.mask8 = 4'hF; e.mask6 = 4'hF; e.last = 1'b1; sb_q.push_back(e);
    end
  endtask

  // Compare a word whenever EX takes it.
  always @(negedge clk) begin
    if (rst_n && ctl_valid && ex_ready) begin
      check("sb_nonempty", 32'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        $display("word op=%b base=%0d mask=%b/%b last=%b", opcode, elem_base, lane_mask, lane_mask_b, vec_last);
        check("opcode", opcode, mon_e.op);
        check("ctl", {reg_dst, alu_src, branch, mem_write, reg_write, mem_to_reg, vreg_write, alu_op}, mon_e.ctl);
        check("elem_base", elem_base, mon_e.base);
        check("lane_mask", lane_mask, mon_e.mask8);
        check("vec_last", vec_last, mon_e.last);
        check("ctl_valid_b", ctl_valid_b, 1);
        check("ctl_b", {reg_dst_b, alu_src_b, branch_b, mem_write_b, reg_write_b, mem_to_reg_b,
                        vreg_write_b, alu_op_b}, mon_e.ctl);
        check("opcode_b", opcode_b, mon_e.op);
        check("elem_base_b", elem_base_b, mon_e.base);
        check("lane_mask_b", lane_mask_b, mon_e.mask6);
        check("vec_last_b", vec_last_b, mon_e.last);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) ex_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [5:0] op);
    bit done = 1'b0;
    instn       = {op, 26'($urandom)};
    instn_valid = 1'b1;
    for (int n = 0; n < 64 && !done; n++) begin
      @(negedge clk);
      done = instn_ready;
      tick();
    end
    instn_valid = 1'b0;
    check("send_accept", 32'(done), 1);
    if (done) push_expected(op);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (sb_q.size() == 0 && state == 2'b00 && !flush) break;
      tick();
      n++;
    end
    check("drain", 32'(sb_q.size()), 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ctl_valid", ctl_valid, 0);
    check("rst_state", state, 0);
    check("rst_flush", flush, 0);
    check("rst_ready", instn_ready, 0);
    check("rst_mask", lane_mask, 0);
    check("rst_last", vec_last, 0);
    check("rst_ready_b", instn_ready_b, 0);
    check("rst_state_b", state_b, 0);
    tick();
    rst_n = 1'b1;
    tick();

    send(OP_ADDI);
    send(OP_RTYPE);
    send(OP_LW);
    send(OP_SW);

    // Two-beat vector op, no backpressure.
    send(OP_RVTYPE);
    @(negedge clk);
    check("vec_state", state, 2'b01);
    check("vec_ready", instn_ready, 0);
    tick();
    wait_idle();

    // Backpressure on beat 0 holds everything, including the beat counter.
    ex_ready = 1'b0;
    send(OP_LW_V);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_valid_b", ctl_valid_b, 1);
      check("bp_base_b", elem_base_b, 0);
      check("bp_mask_b", lane_mask_b, 4'hF);
      check("bp_last_b", vec_last_b, 0);
      check("bp_state", state, 2'b01);
      tick();
    end
    ex_ready = 1'b1;
    wait_idle();

    // BEQ not taken; pcsrc alone is ignored while waiting.
    send(OP_BEQ);
    pcsrc = 1'b1;
    @(negedge clk);
    check("bw_state0", state, 2'b10);
    check("bw_ready0", instn_ready, 0);
    tick();
    br_valid = 1'b1;
    pcsrc    = 1'b0;
    @(negedge clk);
    check("bw_state1", state, 2'b10);
    check("bw_flush1", flush, 0);
    tick();
    br_valid = 1'b0;
    @(negedge clk);
    check("bnt_state", state, 2'b00);
    check("bnt_flush", flush, 0);
    check("bnt_ready", instn_ready, 1);
    tick();

    // BEQ taken with the word still pending: it is squashed.
    ex_ready = 1'b0;
    send(OP_BEQ);
    br_valid = 1'b1;
    pcsrc    = 1'b1;
    @(negedge clk);
    check("bt_pending", ctl_valid, 1);
    tick();
    br_valid = 1'b0;
    pcsrc    = 1'b0;
    if (sb_q.size() != 0) drop_e = sb_q.pop_front();
    nfl = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!flush) break;
      if (i == 0) begin
        check("fl_state", state, 2'b11);
        check("fl_cv0", ctl_valid, 0);
        check("fl_b", flush_b, 1);
      end
      nfl++;
      tick();
    end
    check("fl_len", nfl, 2);
    check("fl_done_state", state, 2'b00);
    check("fl_ready", instn_ready, 1);
    tick();
    ex_ready = 1'b1;

    // br_valid outside BR_WAIT is ignored.
    br_valid = 1'b1;
    pcsrc    = 1'b1;
    tick();
    br_valid = 1'b0;
    pcsrc    = 1'b0;
    @(negedge clk);
    check("nb_state", state, 2'b00);
    check("nb_flush", flush, 0);
    tick();

    // Unknown opcode.
`ifdef VEC_ISSUE_ILLEGAL_TRAP_EN
    send(OP_BAD);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("trap_illegal", illegal_op, 1);
      check("trap_cv", ctl_valid, 0);
      check("trap_ready", instn_ready, 0);
      check("trap_state", state, 2'b00);
      tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("trap_clear", illegal_op, 0);
    check("trap_ready_again", instn_ready, 1);
    tick();
`else
    send(OP_BAD);
    send(OP_SET);
    wait_idle();
`endif

    // Random mix with random EX backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 24; i++) begin
      send(mix[$urandom_range(0, 9)]);
    end
    rand_rdy = 1'b0;
    ex_ready = 1'b1;
    wait_idle();

    // Asynchronous reset in the middle of a vector op.
    ex_ready = 1'b0;
    send(OP_RVTYPE);
    check("pre_rst_state", state, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_cv", ctl_valid, 0);
    check("mid_rst_state", state, 2'b00);
    check("mid_rst_mask", lane_mask, 0);
    check("mid_rst_base", elem_base, 0);
    check("mid_rst_ctl", {reg_dst, alu_src, vreg_write, alu_op}, 0);
    check("mid_rst_cv_b", ctl_valid_b, 0);
    sb_q.delete();
    tick();
    rst_n    = 1'b1;
    ex_ready = 1'b1;
    tick();
    send(OP_ADDI);
    @(negedge clk);
    check("post_rst_alu_src", alu_src, 1);
    check("post_rst_reg_write", reg_write, 1);
    check("post_rst_alu_op", alu_op, 2'b00);
    tick();
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
